i2c_accel_target: RTL

I2C target (slave) model of the tilt sensor's register interface at 7-bit address 0x68: the responder end of the transactions the level controller's I2C master issues. Oversamples SCL/SDA on the system clock, decodes START/STOP/address/data, ACKs matching frames, maintains a register pointer, accepts writes to the power-management register and serves accelerometer/ID registers on reads. Used as a bench/board-emulation peer and as the sensor front end for FPGA-only bring-up.

---
 rtl/i2c_accel_target.sv | 314 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_accel_target.sv
`timescale 1ns/1ps
// i2c_accel_target: I2C target at a 7-bit address that emulates the tilt
// sensor's register interface. SCL/SDA are oversampled on clk_i, bus events
// are decoded, and matching frames are ACKed. A register pointer selects the
// power-management register (read/write), the WHO_AM_I register (read-only)
// and the accelerometer registers. Accelerometer reads come from a snapshot
// that is taken at the address match of each read frame.
//
// state      | meaning
// S_IDLE     | bus free or not addressed; wait for START
// S_ADDR     | shift in address byte + R/W bit
// S_ADDR_ACK | drive ACK for the matched address
// S_PTR      | shift in register pointer byte
// S_PTR_ACK  | drive ACK for the pointer byte
// S_WDATA    | shift in a write data byte
// S_WDATA_ACK| drive ACK for a write data byte
// S_RDATA    | shift out read data, MSB first
// S_RDATA_ACK| sample the master's ACK/NACK
// S_WAIT_STOP| frame not for us or read ended; ignore until STOP/START
module i2c_accel_target #(
  parameter logic [6:0] SLAVE_ADDR = 7'h68,
  parameter logic [7:0] WHO_AM_I   = 8'h68,
  parameter logic [7:0] PWR_RESET  = 8'h40
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe_o,
  input  logic [15:0] accel_x_i,
  input  logic [15:0] accel_y_i,
  input  logic [15:0] accel_z_i,
  output logic [7:0]  pwr_mgmt_o,
  output logic        reg_wr_o,
  output logic [7:0]  reg_addr_o,
  output logic [7:0]  reg_wdata_o,
  output logic        busy_o
);

  localparam logic [7:0] A_XH   = 8'h3B;
  localparam logic [7:0] A_XL   = 8'h3C;
  localparam logic [7:0] A_YH   = 8'h3D;
  localparam logic [7:0] A_YL   = 8'h3E;
  localparam logic [7:0] A_ZH   = 8'h3F;
  localparam logic [7:0] A_ZL   = 8'h40;
  localparam logic [7:0] A_PWR  = 8'h6B;
  localparam logic [7:0] A_WHO  = 8'h75;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK,
    S_WAIT_STOP
  } state_t;

  // synchronizer and edge-history flops
  logic r_scl_s1, r_scl_s2, r_scl_d;
  logic r_sda_s1, r_sda_s2, r_sda_d;

  // FSM state and its companion registers
  state_t     r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic       r_oe, w_oe_nxt;

  // datapath registers
  logic [7:0]  r_shift;
  logic [7:0]  r_tx;
  logic [7:0]  r_ptr;
  logic [7:0]  r_pwr;
  logic        r_rw;
  logic [15:0] r_sh_x, r_sh_y, r_sh_z;
  logic        r_wr;
  logic [7:0]  r_waddr;
  logic [7:0]  r_wdata;

  // decoded events and datapath strobes
  logic       w_scl_rise, w_scl_fall, w_start, w_stop;
  logic       w_sda;
  logic [7:0] w_byte;
  logic [7:0] w_rd_data;
  logic       w_ld_rw, w_snap, w_ld_ptr, w_ptr_inc, w_do_wr, w_ld_tx, w_shift_tx;

  // Bring the asynchronous bus lines into clk_i and keep one sample of history.
  // Idle-high reset values avoid a spurious edge right after reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_scl_s1 <= 1'b1;
      r_scl_s2 <= 1'b1;
      r_scl_d  <= 1'b1;
      r_sda_s1 <= 1'b1;
      r_sda_s2 <= 1'b1;
      r_sda_d  <= 1'b1;
    end else begin
      r_scl_s1 <= scl_i;
      r_scl_s2 <= r_scl_s1;
      r_scl_d  <= r_scl_s2;
      r_sda_s1 <= sda_i;
      r_sda_s2 <= r_sda_s1;
      r_sda_d  <= r_sda_s2;
    end
  end

  assign w_sda      = r_sda_s2;
  assign w_scl_rise = r_scl_s2 & ~r_scl_d;
  assign w_scl_fall = ~r_scl_s2 & r_scl_d;
  assign w_start    = r_scl_s2 & r_scl_d & r_sda_d & ~r_sda_s2;
  assign w_stop     = r_scl_s2 & r_scl_d & ~r_sda_d & r_sda_s2;
  assign w_byte     = {r_shift[6:0], w_sda};

  // Read mux: accelerometer bytes come from the per-frame snapshot.
  always_comb begin
    w_rd_data = 8'h00;
    case (r_ptr)
      A_XH:    w_rd_data = r_sh_x[15:8];
      A_XL:    w_rd_data = r_sh_x[7:0];
      A_YH:    w_rd_data = r_sh_y[15:8];
      A_YL:    w_rd_data = r_sh_y[7:0];
      A_ZH:    w_rd_data = r_sh_z[15:8];
      A_ZL:    w_rd_data = r_sh_z[7:0];
      A_PWR:   w_rd_data = r_pwr;
      A_WHO:   w_rd_data = WHO_AM_I;
      default: w_rd_data = 8'h00;
    endcase
  end

  // State register with bit counter and SDA drive.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_oe    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_oe    <= w_oe_nxt;
    end
  end

  // Next-state, bit counting, SDA drive and datapath strobes.
  // In the *_ACK states r_cnt marks whether the ACK is already being driven
  // (ADDR/PTR/WDATA) or whether the master ACKed (RDATA).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_oe_nxt    = r_oe;
    w_ld_rw     = 1'b0;
    w_snap      = 1'b0;
    w_ld_ptr    = 1'b0;
    w_ptr_inc   = 1'b0;
    w_do_wr     = 1'b0;
    w_ld_tx     = 1'b0;
    w_shift_tx  = 1'b0;
    if (w_start) begin
      w_state_nxt = S_ADDR;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_cnt_nxt   = 4'd0;
      w_oe_nxt    = 1'b0;
    end else begin
      case (r_state)
        S_ADDR: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt = 4'd0;
              if (w_byte[7:1] == SLAVE_ADDR) begin
                w_state_nxt = S_ADDR_ACK;
                w_ld_rw     = 1'b1;
                w_snap      = w_byte[0];
              end else begin
                w_state_nxt = S_WAIT_STOP;
              end
            end
          end
        end
        S_ADDR_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              w_oe_nxt  = 1'b1;
              w_cnt_nxt = 4'd1;
            end else begin
              w_cnt_nxt = 4'd0;
              if (r_rw) begin
                w_state_nxt = S_RDATA;
                w_ld_tx     = 1'b1;
                w_oe_nxt    = ~w_rd_data[7];
              end else begin
                w_state_nxt = S_PTR;
                w_oe_nxt    = 1'b0;
              end
            end
          end
        end
        S_PTR: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = 4'd0;
              w_ld_ptr    = 1'b1;
              w_state_nxt = S_PTR_ACK;
            end
          end
        end
        S_WDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
            if (r_cnt == 4'd7) begin
              w_cnt_nxt   = 4'd0;
              w_do_wr     = 1'b1;
              w_ptr_inc   = 1'b1;
              w_state_nxt = S_WDATA_ACK;
            end
          end
        end
        S_PTR_ACK, S_WDATA_ACK: begin
          if (w_scl_fall) begin
            if (r_cnt == 4'd0) begin
              w_oe_nxt  = 1'b1;
              w_cnt_nxt = 4'd1;
            end else begin
              w_cnt_nxt   = 4'd0;
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_WDATA;
            end
          end
        end
        S_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt = r_cnt + 4'd1;
          end else if (w_scl_fall) begin
            if (r_cnt == 4'd8) begin
              w_oe_nxt    = 1'b0;
              w_cnt_nxt   = 4'd0;
              w_state_nxt = S_RDATA_ACK;
            end else begin
              w_oe_nxt   = ~r_tx[6];
              w_shift_tx = 1'b1;
            end
          end
        end
        S_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_ptr_inc = 1'b1;
            if (!w_sda) begin
              w_cnt_nxt = 4'd1;
            end else begin
              w_state_nxt = S_WAIT_STOP;
            end
          end else if (w_scl_fall && r_cnt == 4'd1) begin
            w_cnt_nxt   = 4'd0;
            w_state_nxt = S_RDATA;
            w_ld_tx     = 1'b1;
            w_oe_nxt    = ~w_rd_data[7];
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // Datapath: receive shifter, pointer, register file, snapshot, write strobe.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_shift <= 8'h00;
      r_tx    <= 8'h00;
      r_ptr   <= 8'h00;
      r_pwr   <= PWR_RESET;
      r_rw    <= 1'b0;
      r_sh_x  <= 16'h0000;
      r_sh_y  <= 16'h0000;
      r_sh_z  <= 16'h0000;
      r_wr    <= 1'b0;
      r_waddr <= 8'h00;
      r_wdata <= 8'h00;
    end else begin
      r_wr <= 1'b0;
      if (w_scl_rise) r_shift <= w_byte;
      if (w_ld_rw) r_rw <= w_byte[0];
      if (w_snap) begin
        r_sh_x <= accel_x_i;
        r_sh_y <= accel_y_i;
        r_sh_z <= accel_z_i;
      end
      if (w_ld_ptr) r_ptr <= w_byte;
      else if (w_ptr_inc) r_ptr <= r_ptr + 8'd1;
      if (w_do_wr) begin
        r_wr    <= 1'b1;
        r_waddr <= r_ptr;
        r_wdata <= w_byte;
        if (r_ptr == A_PWR) r_pwr <= w_byte;
      end
      if (w_ld_tx) r_tx <= w_rd_data;
      else if (w_shift_tx) r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  assign sda_oe_o    = r_oe;
  assign pwr_mgmt_o  = r_pwr;
  assign reg_wr_o    = r_wr;
  assign reg_addr_o  = r_waddr;
  assign reg_wdata_o = r_wdata;
  assign busy_o      = (r_state != S_IDLE) && (r_state != S_WAIT_STOP);

endmodule
